// File: rtl/reg_file_rename_pkg.sv
// Shared constants and helpers for the architectural register file with rename tracking.
package reg_file_rename_pkg;

  localparam int DATA_WID    = 32;
  localparam int REG_POS_WID = 5;
  localparam int ROB_POS_WID = 4;
  localparam int NUM_REGS    = 32;

  // x0 never holds state and never carries a producer tag.
  function automatic logic is_x0(input logic [REG_POS_WID-1:0] idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/reg_read_port.sv
// One operand read port: x0 masking plus the optional same-cycle commit bypass.
// REGFILE_BYPASS_EN selects whether a matching commit is forwarded in the same cycle.
module reg_read_port
  import reg_file_rename_pkg::*;
#(
  parameter int DATA_W    = DATA_WID,
  parameter int ROB_POS_W = ROB_POS_WID
) (
  input  logic [REG_POS_WID-1:0] idx,
  input  logic [DATA_W-1:0]      reg_val,
  input  logic                   reg_busy,
  input  logic [ROB_POS_W-1:0]   reg_tag,
  input  logic                   commit_fire,
  input  logic [REG_POS_WID-1:0] commit_rd,
  input  logic [DATA_W-1:0]      commit_val,
  input  logic [ROB_POS_W-1:0]   commit_rob_pos,
  output logic [DATA_W-1:0]      rd_val,
  output logic                   rd_busy,
  output logic [ROB_POS_W-1:0]   rd_rob_pos
);

`ifdef REGFILE_BYPASS_EN
  logic bypass_hit;

  // Forward only when the committing entry is the register's current owner.
  assign bypass_hit = commit_fire && (commit_rd == idx) && reg_busy &&
                      (reg_tag == commit_rob_pos);

  always_comb begin
    rd_val     = reg_val;
    rd_busy    = reg_busy;
    rd_rob_pos = reg_tag;
    if (bypass_hit) begin
      rd_val  = commit_val;
      rd_busy = 1'b0;
    end
    if (is_x0(idx)) begin
      rd_val     = '0;
      rd_busy    = 1'b0;
      rd_rob_pos = '0;
    end
  end
`else
  logic unused_commit;
  assign unused_commit = ^{commit_fire, commit_rd, commit_val, commit_rob_pos};

  always_comb begin
    rd_val     = reg_val;
    rd_busy    = reg_busy;
    rd_rob_pos = reg_tag;
    if (is_x0(idx)) begin
      rd_val     = '0;
      rd_busy    = 1'b0;
      rd_rob_pos = '0;
    end
  end
`endif

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file holding committed values, busy bits and producer ROB tags.
// Build option REGFILE_BYPASS_EN adds same-cycle commit forwarding on the read ports.
module reg_file_rename
  import reg_file_rename_pkg::*;
#(
  parameter int DATA_W    = DATA_WID,
  parameter int ROB_POS_W = ROB_POS_WID
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   commit,
  input  logic [REG_POS_WID-1:0] commit_rd,
  input  logic [DATA_W-1:0]      commit_val,
  input  logic [ROB_POS_W-1:0]   commit_rob_pos,
  input  logic                   rename,
  input  logic [REG_POS_WID-1:0] rename_rd,
  input  logic [ROB_POS_W-1:0]   rename_rob_pos,
  input  logic [REG_POS_WID-1:0] rs1_idx,
  input  logic [REG_POS_WID-1:0] rs2_idx,
  output logic [DATA_W-1:0]      rs1_val,
  output logic [DATA_W-1:0]      rs2_val,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic [ROB_POS_W-1:0]   rs1_rob_pos,
  output logic [ROB_POS_W-1:0]   rs2_rob_pos
);

  logic [DATA_W-1:0]    val_q [NUM_REGS];
  logic [DATA_W-1:0]    val_d [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_d;
  logic [ROB_POS_W-1:0] tag_q [NUM_REGS];
  logic [ROB_POS_W-1:0] tag_d [NUM_REGS];

  logic commit_fire;
  assign commit_fire = commit && rdy;

  // Ordering inside this block encodes priority: commit clears first, then
  // rollback wipes busy or a rename re-marks the register for its new owner.
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy) begin
      if (commit) begin
        if (!is_x0(commit_rd)) begin
          val_d[commit_rd] = commit_val;
        end
        if (tag_q[commit_rd] == commit_rob_pos) begin
          busy_d[commit_rd] = 1'b0;
        end
      end
      if (rollback) begin
        busy_d = '0;
      end else if (rename && !is_x0(rename_rd)) begin
        busy_d[rename_rd] = 1'b1;
        tag_d[rename_rd]  = rename_rob_pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  reg_read_port #(
    .DATA_W    (DATA_W),
    .ROB_POS_W (ROB_POS_W)
  ) u_rs1_port (
    .idx            (rs1_idx),
    .reg_val        (val_q[rs1_idx]),
    .reg_busy       (busy_q[rs1_idx]),
    .reg_tag        (tag_q[rs1_idx]),
    .commit_fire    (commit_fire),
    .commit_rd      (commit_rd),
    .commit_val     (commit_val),
    .commit_rob_pos (commit_rob_pos),
    .rd_val         (rs1_val),
    .rd_busy        (rs1_busy),
    .rd_rob_pos     (rs1_rob_pos)
  );

  reg_read_port #(
    .DATA_W    (DATA_W),
    .ROB_POS_W (ROB_POS_W)
  ) u_rs2_port (
    .idx            (rs2_idx),
    .reg_val        (val_q[rs2_idx]),
    .reg_busy       (busy_q[rs2_idx]),
    .reg_tag        (tag_q[rs2_idx]),
    .commit_fire    (commit_fire),
    .commit_rd      (commit_rd),
    .commit_val     (commit_val),
    .commit_rob_pos (commit_rob_pos),
    .rd_val         (rs2_val),
    .rd_busy        (rs2_busy),
    .rd_rob_pos     (rs2_rob_pos)
  );

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename: rename/commit/rollback scenarios with hand-computed results.
module tb_reg_file_rename;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        commit;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [3:0]  commit_rob_pos;
  logic        rename;
  logic [4:0]  rename_rd;
  logic [3:0]  rename_rob_pos;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [3:0]  rs1_rob_pos;
  logic [3:0]  rs2_rob_pos;

  int n_pass  = 0;
  int n_total = 0;

  reg_file_rename dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .commit         (commit),
    .commit_rd      (commit_rd),
    .commit_val     (commit_val),
    .commit_rob_pos (commit_rob_pos),
    .rename         (rename),
    .rename_rd      (rename_rd),
    .rename_rob_pos (rename_rob_pos),
    .rs1_idx        (rs1_idx),
    .rs2_idx        (rs2_idx),
    .rs1_val        (rs1_val),
    .rs2_val        (rs2_val),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .rs1_rob_pos    (rs1_rob_pos),
    .rs2_rob_pos    (rs2_rob_pos)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    commit   = 1'b0;
    rename   = 1'b0;
    rollback = 1'b0;
  endtask

  task automatic drive_rename(input logic [4:0] rd, input logic [3:0] pos);
    rename         = 1'b1;
    rename_rd      = rd;
    rename_rob_pos = pos;
  endtask

  task automatic drive_commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] pos);
    commit         = 1'b1;
    commit_rd      = rd;
    commit_val     = v;
    commit_rob_pos = pos;
  endtask

  task automatic read_regs(input logic [4:0] a, input logic [4:0] b);
    rs1_idx = a;
    rs2_idx = b;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; commit = 1'b0; rename = 1'b0;
    commit_rd = '0; commit_val = '0; commit_rob_pos = '0;
    rename_rd = '0; rename_rob_pos = '0; rs1_idx = '0; rs2_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    read_regs(5'd5, 5'd31);
    n_total++;
    if (rs1_val !== 32'h0) $display("FAIL reset_x5_val got=%h exp=%h", rs1_val, 32'h0);
    else n_pass++;
    n_total++;
    if (rs1_busy !== 1'b0 || rs1_rob_pos !== 4'd0)
      $display("FAIL reset_x5_busy got=%b/%0d exp=0/0", rs1_busy, rs1_rob_pos);
    else n_pass++;
    n_total++;
    if (rs2_val !== 32'h0 || rs2_busy !== 1'b0)
      $display("FAIL reset_x31 got=%h/%b exp=0/0", rs2_val, rs2_busy);
    else n_pass++;
  endtask

  task automatic test_rename_commit();
    drive_rename(5'd5, 4'd3);
    tick();
    read_regs(5'd5, 5'd6);
    n_total++;
    if (rs1_busy !== 1'b1 || rs1_rob_pos !== 4'd3)
      $display("FAIL rename_x5 got=%b/%0d exp=1/3", rs1_busy, rs1_rob_pos);
    else n_pass++;
    n_total++;
    if (rs2_busy !== 1'b0) $display("FAIL rename_x6_untouched got=%b exp=0", rs2_busy);
    else n_pass++;
    drive_commit(5'd5, 32'hDEADBEEF, 4'd3);
    tick();
    read_regs(5'd5, 5'd0);
    n_total++;
    if (rs1_val !== 32'hDEADBEEF || rs1_busy !== 1'b0)
      $display("FAIL commit_x5 got=%h/%b exp=deadbeef/0", rs1_val, rs1_busy);
    else n_pass++;
  endtask

  task automatic test_younger_rename();
    drive_rename(5'd7, 4'd2);
    tick();
    drive_rename(5'd7, 4'd9);
    tick();
    drive_commit(5'd7, 32'h11, 4'd2);
    read_regs(5'd7, 5'd0);
    // Stale tag: no same-cycle forwarding in either build.
    n_total++;
    if (rs1_busy !== 1'b1 || rs1_rob_pos !== 4'd9)
      $display("FAIL stale_commit_same_cycle got=%b/%0d exp=1/9", rs1_busy, rs1_rob_pos);
    else n_pass++;
    tick();
    read_regs(5'd7, 5'd0);
    n_total++;
    if (rs1_val !== 32'h11 || rs1_busy !== 1'b1 || rs1_rob_pos !== 4'd9)
      $display("FAIL stale_commit_x7 got=%h/%b/%0d exp=11/1/9", rs1_val, rs1_busy, rs1_rob_pos);
    else n_pass++;
    drive_commit(5'd7, 32'h22, 4'd9);
    tick();
    read_regs(5'd0, 5'd7);
    n_total++;
    if (rs2_val !== 32'h22 || rs2_busy !== 1'b0)
      $display("FAIL owner_commit_x7 got=%h/%b exp=22/0", rs2_val, rs2_busy);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    drive_rename(5'd4, 4'd1);
    tick();
    drive_commit(5'd4, 32'h5, 4'd1);
    drive_rename(5'd4, 4'd6);
    tick();
    read_regs(5'd4, 5'd0);
    n_total++;
    if (rs1_val !== 32'h5 || rs1_busy !== 1'b1 || rs1_rob_pos !== 4'd6)
      $display("FAIL same_cycle_x4 got=%h/%b/%0d exp=5/1/6", rs1_val, rs1_busy, rs1_rob_pos);
    else n_pass++;
  endtask

  task automatic test_rollback();
    drive_rename(5'd1, 4'd1);
    tick();
    drive_rename(5'd2, 4'd2);
    tick();
    drive_rename(5'd3, 4'd3);
    tick();
    rollback = 1'b1;
    drive_commit(5'd1, 32'h40, 4'd1);
    drive_rename(5'd8, 4'd10);
    tick();
    read_regs(5'd1, 5'd2);
    n_total++;
    if (rs1_val !== 32'h40 || rs1_busy !== 1'b0)
      $display("FAIL rollback_x1 got=%h/%b exp=40/0", rs1_val, rs1_busy);
    else n_pass++;
    n_total++;
    if (rs2_busy !== 1'b0) $display("FAIL rollback_x2 got=%b exp=0", rs2_busy);
    else n_pass++;
    read_regs(5'd3, 5'd8);
    n_total++;
    if (rs1_busy !== 1'b0) $display("FAIL rollback_x3 got=%b exp=0", rs1_busy);
    else n_pass++;
    n_total++;
    if (rs2_busy !== 1'b0) $display("FAIL rollback_rename_x8 got=%b exp=0", rs2_busy);
    else n_pass++;
    n_total++;
    if (dut.busy_q !== 32'h0) $display("FAIL rollback_all_busy got=%h exp=0", dut.busy_q);
    else n_pass++;
  endtask

  task automatic test_x0();
    drive_rename(5'd0, 4'd4);
    drive_commit(5'd0, 32'hFF, 4'd4);
    read_regs(5'd0, 5'd0);
    n_total++;
    if (rs1_val !== 32'h0 || rs1_busy !== 1'b0)
      $display("FAIL x0_same_cycle got=%h/%b exp=0/0", rs1_val, rs1_busy);
    else n_pass++;
    tick();
    read_regs(5'd0, 5'd0);
    n_total++;
    if (rs1_val !== 32'h0 || rs1_busy !== 1'b0 || rs1_rob_pos !== 4'd0)
      $display("FAIL x0_after got=%h/%b/%0d exp=0/0/0", rs1_val, rs1_busy, rs1_rob_pos);
    else n_pass++;
    n_total++;
    if (rs2_val !== 32'h0 || rs2_busy !== 1'b0)
      $display("FAIL x0_rs2 got=%h/%b exp=0/0", rs2_val, rs2_busy);
    else n_pass++;
  endtask

  task automatic test_bypass();
    drive_rename(5'd9, 4'd5);
    tick();
    drive_commit(5'd9, 32'h77, 4'd5);
    read_regs(5'd9, 5'd5);
`ifdef REGFILE_BYPASS_EN
    n_total++;
    if (rs1_busy !== 1'b0 || rs1_val !== 32'h77)
      $display("FAIL bypass_x9 got=%b/%h exp=0/77", rs1_busy, rs1_val);
    else n_pass++;
`else
    n_total++;
    if (rs1_busy !== 1'b1 || rs1_rob_pos !== 4'd5)
      $display("FAIL no_bypass_x9 got=%b/%0d exp=1/5", rs1_busy, rs1_rob_pos);
    else n_pass++;
`endif
    n_total++;
    if (rs2_val !== 32'hDEADBEEF || rs2_busy !== 1'b0)
      $display("FAIL bypass_other_port got=%h/%b exp=deadbeef/0", rs2_val, rs2_busy);
    else n_pass++;
    tick();
    read_regs(5'd9, 5'd0);
    n_total++;
    if (rs1_val !== 32'h77 || rs1_busy !== 1'b0)
      $display("FAIL commit_x9 got=%h/%b exp=77/0", rs1_val, rs1_busy);
    else n_pass++;
  endtask

  task automatic test_rdy_low();
    rdy = 1'b0;
    drive_rename(5'd10, 4'd7);
    drive_commit(5'd5, 32'h1234, 4'd0);
    tick();
    rollback = 1'b1;
    drive_rename(5'd12, 4'd8);
    tick();
    rdy = 1'b1;
    read_regs(5'd10, 5'd5);
    n_total++;
    if (rs1_busy !== 1'b0) $display("FAIL rdy_low_rename got=%b exp=0", rs1_busy);
    else n_pass++;
    n_total++;
    if (rs2_val !== 32'hDEADBEEF) $display("FAIL rdy_low_commit got=%h exp=deadbeef", rs2_val);
    else n_pass++;
    read_regs(5'd4, 5'd12);
    n_total++;
    if (rs1_val !== 32'h5 || rs2_busy !== 1'b0)
      $display("FAIL rdy_low_hold got=%h/%b exp=5/0", rs1_val, rs2_busy);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    drive_rename(5'd11, 4'd12);
    tick();
    rst = 1'b1;
    drive_rename(5'd13, 4'd1);
    tick();
    rst = 1'b0;
    read_regs(5'd11, 5'd9);
    n_total++;
    if (rs1_busy !== 1'b0 || rs1_rob_pos !== 4'd0)
      $display("FAIL reset_clears_x11 got=%b/%0d exp=0/0", rs1_busy, rs1_rob_pos);
    else n_pass++;
    n_total++;
    if (rs2_val !== 32'h0) $display("FAIL reset_clears_x9 got=%h exp=0", rs2_val);
    else n_pass++;
    read_regs(5'd13, 5'd0);
    n_total++;
    if (rs1_busy !== 1'b0) $display("FAIL reset_beats_rename got=%b exp=0", rs1_busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rename_commit();
    test_younger_rename();
    test_same_cycle();
    test_rollback();
    test_x0();
    test_bypass();
    test_rdy_low();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
